csa_serial_ctrl: RTL and testbench

Sequencing controller that performs a WIDTH-bit addition by streaming 4-bit nibbles, least significant first, through one internal 4-bit carry-skip adder slice. The slice is combinational: ripple sum/carry plus an all-propagate bypass that selects carry-in. The controller registers the inter-nibble carry and accumulates the result. It also counts how many nibbles resolved their carry through the skip path. It sits between a request source and a result consumer, with a valid/ready handshake on each side.

---
 rtl/csa_serial_ctrl.sv | 124 ++++++++++++
 tb/tb_csa_serial_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/csa_serial_ctrl.sv
// Serial WIDTH-bit adder controller: streams 4-bit nibbles LSB-first through one
// carry-skip adder slice, registering the inter-nibble carry and counting skip hits.
module csa_serial_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNTW  = $clog2(WIDTH/4+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic [CNTW-1:0]  skip_cnt,
  output logic             busy
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [IDXW-1:0]  idx;

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [4:0] ripple;
  logic       slice_skip;
  logic       slice_cout;
  logic       last_nib;

  // Carry-skip slice: when every bit propagates, carry-out is simply carry-in
  always_comb begin
    a_nib      = a_reg[4*idx +: 4];
    b_nib      = b_reg[4*idx +: 4];
    ripple     = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
    slice_skip = &(a_nib ^ b_nib);
    slice_cout = slice_skip ? carry : ripple[4];
    last_nib   = (idx == IDXW'(NIB-1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) next_state = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_nib) next_state = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Results persist through IDLE and are only cleared by the next accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      sum_out  <= '0;
      cout_out <= 1'b0;
      skip_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_reg    <= a_in;
            b_reg    <= b_in;
            carry    <= cin_in;
            sum_out  <= '0;
            skip_cnt <= '0;
            idx      <= '0;
          end
        end
        RUN: begin
          sum_out[4*idx +: 4] <= ripple[3:0];
          carry               <= slice_cout;
          skip_cnt            <= skip_cnt + CNTW'(slice_skip);
          if (last_nib) begin
            cout_out <= slice_cout;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_serial_ctrl.sv
// Directed bench for csa_serial_ctrl (WIDTH=16): hand-computed vectors, backpressure,
// mid-run reset and a back-to-back stream checked against a reference adder.
module tb_csa_serial_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        cin_in;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] sum_out;
  logic        cout_out;
  logic [2:0]  skip_cnt;
  logic        busy;

  int vectors;
  int miscompares;
  int edge_no;

  csa_serial_ctrl #(.WIDTH(16), .CNTW(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a_in(a_in),
    .b_in(b_in),
    .cin_in(cin_in),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .sum_out(sum_out),
    .cout_out(cout_out),
    .skip_cnt(skip_cnt),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one accept edge (caller ensures IDLE)
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic c);
    a_in        = a;
    b_in        = b;
    cin_in      = c;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic waitResult(output int cycles);
    cycles = 0;
    while (!res_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic checkResult(input string tag, input logic [15:0] s, input logic c, input logic [2:0] k);
    checkOutput({tag, "_sum"}, 32'(sum_out), 32'(s));
    checkOutput({tag, "_cout"}, 32'(cout_out), 32'(c));
    checkOutput({tag, "_skip"}, 32'(skip_cnt), 32'(k));
  endtask

  function automatic logic [2:0] refSkip(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] p;
    logic [2:0]  n;
    p = a ^ b;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (p[4*i +: 4] == 4'hF) n = n + 3'd1;
    end
    return n;
  endfunction

  initial begin
    int          cycles;
    int          last_accept;
    logic [16:0] full;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;

    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start_valid = 1'b1;
    res_ready   = 1'b0;
    a_in        = 16'h1111;
    b_in        = 16'h2222;
    cin_in      = 1'b1;

    // Reset state, with start_valid asserted and ignored
    tick();
    tick();
    checkOutput("rst_start_ready", 32'(start_ready), 32'd1);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkResult("rst", 16'h0000, 1'b0, 3'd0);
    rst_n       = 1'b1;
    start_valid = 1'b0;
    tick();

    // Plain add, no skips, latency of 4 cycles
    applyStimulus(16'h1234, 16'h4321, 1'b0);
    checkOutput("v1_busy_run", 32'(busy), 32'd1);
    checkOutput("v1_ready_run", 32'(start_ready), 32'd0);
    waitResult(cycles);
    checkOutput("v1_latency", 32'(cycles), 32'd4);
    checkResult("v1", 16'h5555, 1'b0, 3'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput("v1_back_idle", 32'(start_ready), 32'd1);
    checkResult("v1_held", 16'h5555, 1'b0, 3'd0);

    // Carry-in rides the skip path through every nibble
    applyStimulus(16'hFFFF, 16'h0000, 1'b1);
    waitResult(cycles);
    checkOutput("v2_latency", 32'(cycles), 32'd4);
    checkResult("v2", 16'h0000, 1'b1, 3'd4);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // All-propagate operands, then hold in DONE under backpressure
    applyStimulus(16'hA5A5, 16'h5A5A, 1'b0);
    waitResult(cycles);
    checkOutput("v3_latency", 32'(cycles), 32'd4);
    checkResult("v3", 16'hFFFF, 1'b0, 3'd4);
    start_valid = 1'b1;
    a_in        = 16'h0101;
    b_in        = 16'h0202;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_res_valid", 32'(res_valid), 32'd1);
      checkOutput("bp_start_ready", 32'(start_ready), 32'd0);
      checkResult("bp", 16'hFFFF, 1'b0, 3'd4);
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    tick();
    res_ready   = 1'b0;
    checkOutput("bp_release_ready", 32'(start_ready), 32'd1);
    checkOutput("bp_release_valid", 32'(res_valid), 32'd0);
    checkOutput("bp_release_busy", 32'(busy), 32'd0);
    checkResult("bp_no_accept", 16'hFFFF, 1'b0, 3'd4);

    // MSB carry-out with no skips
    applyStimulus(16'h8000, 16'h8000, 1'b0);
    waitResult(cycles);
    checkOutput("v4_latency", 32'(cycles), 32'd4);
    checkResult("v4", 16'h0000, 1'b1, 3'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Reset after two RUN edges discards the in-flight work
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b0);
    tick();
    tick();
    checkOutput("mid_busy", 32'(busy), 32'd1);
    rst_n       = 1'b0;
    start_valid = 1'b1;
    tick();
    checkOutput("mid_rst_ready", 32'(start_ready), 32'd1);
    checkOutput("mid_rst_valid", 32'(res_valid), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkResult("mid_rst", 16'h0000, 1'b0, 3'd0);
    rst_n       = 1'b1;
    start_valid = 1'b0;
    tick();
    applyStimulus(16'h0FFF, 16'h0001, 1'b0);
    waitResult(cycles);
    checkOutput("v5_latency", 32'(cycles), 32'd4);
    checkResult("v5", 16'h1000, 1'b0, 3'd2);
    res_ready = 1'b1;
    tick();

    // Back-to-back stream: accepts every 6 edges
    start_valid = 1'b1;
    last_accept = 0;
    for (int i = 0; i < 20; i++) begin
      ra     = 16'($urandom);
      rb     = (i % 4 == 0) ? ~ra : 16'($urandom);
      rc     = 1'($urandom);
      a_in   = ra;
      b_in   = rb;
      cin_in = rc;
      full   = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
      checkOutput("b2b_ready", 32'(start_ready), 32'd1);
      tick();
      if (i > 0) checkOutput("b2b_spacing", 32'(edge_no - last_accept), 32'd6);
      last_accept = edge_no;
      waitResult(cycles);
      checkOutput("b2b_latency", 32'(cycles), 32'd4);
      checkResult("b2b", full[15:0], full[16], refSkip(ra, rb));
      tick();
    end
    start_valid = 1'b0;
    res_ready   = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
